// File: rtl/mvm_pipe_ctrl.sv
// Sequencer for the MVM datapath: weight programming, zero-skipping element issue,
// and a fetch/multiply/accumulate valid pipeline.
module mvm_pipe_ctrl #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N),
  parameter int LEN_W = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prog,
  input  logic             prog_valid,
  input  logic             abort,
  input  logic             ip_zero,
  output logic [IDX_W-1:0] ip_addr,
  output logic             wt_rd_en,
  output logic             wt_we,
  output logic [IDX_W-1:0] wt_addr,
  output logic             prog_ready,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] skip_cnt
);
  localparam int STAGES = 2;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(N-1);

  typedef enum logic [2:0] {IDLE, PROG, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, row;
  logic [LEN_W-1:0]  len_q, len_clamp, last_idx;
  logic              drain_q;
  logic [STAGES:1]   vld_pipe;
  logic              issue, kill, run_last;

  assign len_clamp = (len > LEN_W'(N)) ? LEN_W'(N) : len;
  assign last_idx  = len_q - LEN_W'(1);
  assign run_last  = (LEN_W'(idx) == last_idx);
  assign kill      = abort && (state != IDLE);
  assign issue     = (state == RUN) && !ip_zero;

  assign wt_rd_en   = issue;
  assign wt_we      = (state == PROG) && prog_valid;
  assign ip_addr    = (state == RUN) ? idx : '0;
  assign wt_addr    = (state == PROG) ? row : ((state == RUN) ? idx : '0);
  assign prog_ready = (state == PROG);
  assign acc_clr    = (state == CLEAR);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign mac_en     = vld_pipe[1];
  assign acc_en     = vld_pipe[STAGES];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (!abort) begin
               if (prog)       state_nxt = PROG;
               else if (start) state_nxt = CLEAR;
             end
      PROG:  if (prog_valid && row == LAST_ROW) state_nxt = IDLE;
      CLEAR: state_nxt = (len_q == '0) ? DONE : RUN;
      RUN:   if (run_last) state_nxt = DRAIN;
      DRAIN: if (drain_q) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      row      <= '0;
      len_q    <= '0;
      drain_q  <= 1'b0;
      vld_pipe <= '0;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= kill ? '0 : {vld_pipe[STAGES-1:1], issue};
      if (!kill) begin
        unique case (state)
          IDLE: begin
            // Row counter restarts on entry so an aborted program pass leaves no residue.
            if (!abort && prog) row <= '0;
            if (!abort && !prog && start) len_q <= len_clamp;
          end
          PROG:  if (prog_valid) row <= (row == LAST_ROW) ? '0 : row + IDX_W'(1);
          CLEAR: begin
            idx      <= '0;
            skip_cnt <= '0;
            drain_q  <= 1'b0;
          end
          RUN: begin
            if (ip_zero)   skip_cnt <= skip_cnt + LEN_W'(1);
            if (!run_last) idx      <= idx + IDX_W'(1);
          end
          DRAIN: drain_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/mvm_pipe_ctrl.md
# mvm_pipe_ctrl

Parametrised, pipelined control unit for the matrix-vector-multiply datapath. It sequences weight programming and MVM passes over a runtime-selectable vector length of up to `N` elements. Zero input elements are skipped without spending a weight read. One element is issued per cycle through a 3-stage fetch / multiply / accumulate pipeline. It sits between the core controller (start/done handshake) and the input buffer, weight memory and MAC/accumulator datapath.

## Interface
Parameters:
- `N`, 16, maximum vector length / weight rows; must be ≥ 2.
- `IDX_W`, `$clog2(N)`, element/row index width.
- `LEN_W`, `$clog2(N+1)`, length and count width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin an MVM pass; sampled only in IDLE.
- `len` in LEN_W: vector length; sampled with `start`; values > N are clamped to N.
- `prog` in 1: begin weight programming; sampled only in IDLE; wins over `start`.
- `prog_valid` in 1: a weight row is present on the write data bus.
- `abort` in 1: cancel the current operation.
- `ip_zero` in 1: the input element at `ip_addr` is zero (combinational from the input buffer).
- `ip_addr` out IDX_W: input element index under examination.
- `wt_rd_en` out 1: weight row read, at row `wt_addr`.
- `wt_we` out 1: weight row write, at row `wt_addr`.
- `wt_addr` out IDX_W: weight row address.
- `prog_ready` out 1: high in PROG.
- `acc_clr` out 1: clear accumulators.
- `mac_en` out 1: product stage valid.
- `acc_en` out 1: accumulate stage valid.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `skip_cnt` out LEN_W: number of zero elements skipped in the last completed pass.

## Operation
States: IDLE, PROG, CLEAR, RUN, DRAIN, DONE.

State transitions:
- IDLE: `prog` → PROG; else `start` → CLEAR; else stay in IDLE.
- PROG:
  - `prog_ready`=1; `wt_we`=`prog_valid`; `wt_addr`=row counter.
  - The row counter increments on each `prog_valid` cycle.
  - After row N-1 is written → IDLE.
  - `prog_valid` low stalls the counter. There is no timeout.
- CLEAR:
  - `acc_clr`=1; the index is cleared to 0; `skip_cnt` is cleared.
  - Latched length 0 → DONE; else → RUN.
- RUN, one element per cycle:
  - `ip_addr`=`wt_addr`=index.
  - `ip_zero`=1: no read, and `skip_cnt` increments.
  - `ip_zero`=0: `wt_rd_en`=1 (Mealy on `ip_zero`).
  - The index increments every cycle.
  - After index len-1 → DRAIN.
- DRAIN: 2 cycles; no new issue → DONE.
- DONE: `done`=1 → IDLE.

Pipeline and control rules:
- Pipeline valid bits: `mac_en` = `wt_rd_en` delayed 1 cycle; `acc_en` = `mac_en` delayed 1 cycle. Both advance in every state.
- `abort`, any non-IDLE state:
  - Next state is IDLE.
  - Pipeline valid bits are cleared, so `mac_en` and `acc_en` are 0 next cycle.
  - No `done` pulse; `skip_cnt` holds its partial value.
- `abort` together with `prog` or `start` in IDLE: `abort` wins; stay in IDLE.
- `start` or `prog` while busy is ignored and not queued.
- `skip_cnt` holds after DONE until the next CLEAR. It never exceeds the latched length.
- Index, row counter and `skip_cnt` never wrap: all terminal compares are made against the last value.

## Timing
- Reset state, next edge:
  - State IDLE; index, row counter, `skip_cnt` and pipeline valid bits are 0.
  - All outputs are 0 (`busy`=0, `done`=0, addresses 0).
- Reset mid-operation behaves like `abort`, and additionally zeroes `skip_cnt`.
- `start` high in cycle 0 (latched length L ≥ 1):
  - CLEAR in cycle 1.
  - RUN in cycles 2..L+1.
  - DRAIN in cycles L+2..L+3.
  - DONE (`done`=1) in cycle L+4.
  - Back-to-back `start` is accepted in cycle L+5.
- L=0: CLEAR in cycle 1, `done` in cycle 2.
- The last `acc_en` for a non-skipped element L-1 is in cycle L+3, one cycle before `done`.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- PROG with `prog_valid` held high: N write cycles, then IDLE; `busy` is high for N cycles.
- All outputs except `wt_rd_en` are decodes of registered state only.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; `busy`=0.
- N=16, `start`, `len`=16, `ip_zero`=0 always → 16 `wt_rd_en` at addresses 0..15; `mac_en` and `acc_en` each 16 cycles; `done` in cycle 20; `skip_cnt`=0.
- `len`=8, `ip_zero` high at indices 1, 4, 7 → `wt_rd_en` at 0, 2, 3, 5, 6 only; `done` in cycle 12; `skip_cnt`=3.
- `len`=0 → `acc_clr` in cycle 1, `done` in cycle 2, no `wt_rd_en`; `len`=20 → clamped, `done` in cycle 20.
- `prog` with `prog_valid` low every third cycle → `wt_we` at rows 0..15 exactly once each; IDLE after row 15; `prog`+`start` together → PROG taken.
- `abort` in RUN index 5 → IDLE next cycle, `mac_en`/`acc_en` 0 next cycle, no `done`; a new `start` completes normally.
